// File: rtl/mem_fill_arbiter_if.sv
// Request, main-memory and fill-steering signals shared between mem_fill_arbiter
// (master) and the caches/main memory around it (slave).
interface mem_fill_arbiter_if;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        dcache_wr_req;
    logic [15:0] dcache_wr_addr;
    logic [15:0] dcache_wr_data;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        icache_fill_we;
    logic        dcache_fill_we;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        wr_ack;
    logic        busy;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_valid, mem_rdata,
        output mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
               icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done,
               wr_ack, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
               dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_valid, mem_rdata,
        input  mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
               icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done,
               wr_ack, busy
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares the main-memory port between write-through stores, D-cache fills and
// I-cache fills; issues block reads back-to-back and steers returns to the owner.
module mem_fill_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_fill_arbiter_if.master bus
);
    localparam int              BLOCK_BYTES = 2 * BLOCK_WORDS;
    localparam int              CW          = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0]   LAST_IDX    = CW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0]   CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [15:0]     ALIGN_MASK  = ~(16'(BLOCK_BYTES) - 16'd1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        FILL_ISSUE = 2'd2,
        FILL_DRAIN = 2'd3
    } state_t;

    state_t        state_r;
    logic          owner_d_r;
    logic [15:0]   base_r;
    logic [CW-1:0] issue_cnt_r;
    logic [CW-1:0] recv_cnt_r;
    logic          mem_enable_r;
    logic          mem_wr_r;
    logic [15:0]   mem_addr_r;
    logic [15:0]   mem_wdata_r;
    logic          wr_ack_r;
    logic          busy_r;

    logic          fill_active_s;
    logic          last_word_s;
    logic [CW-1:0] issue_next_s;
    logic [15:0]   grant_base_s;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Byte address of word idx in a block; 16-bit modulo so the top block never carries out.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [CW-1:0] idx);
        return base + 16'({idx, 1'b0});
    endfunction

    // Return steering and grant address: valid data counts only while a fill is live.
    always_comb begin
        fill_active_s = 1'b0;
        if (!rst && bus.mem_data_valid && (state_r == FILL_ISSUE || state_r == FILL_DRAIN)) begin
            fill_active_s = 1'b1;
        end else begin
            fill_active_s = 1'b0;
        end
        last_word_s  = fill_active_s && (recv_cnt_r == LAST_IDX);
        issue_next_s = issue_cnt_r + CNT_ONE;
        grant_base_s = 16'h0000;
        if (bus.dcache_miss) begin
            grant_base_s = block_base(bus.dcache_miss_addr);
        end else begin
            grant_base_s = block_base(bus.icache_miss_addr);
        end
    end

    // Arbitration FSM with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_d_r    <= 1'b0;
            base_r       <= 16'h0000;
            issue_cnt_r  <= {CW{1'b0}};
            recv_cnt_r   <= {CW{1'b0}};
            mem_enable_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= 16'h0000;
            mem_wdata_r  <= 16'h0000;
            wr_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (fill_active_s) begin
                recv_cnt_r <= recv_cnt_r + CNT_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (bus.dcache_wr_req) begin
                        state_r      <= WRITE;
                        mem_enable_r <= 1'b1;
                        mem_wr_r     <= 1'b1;
                        mem_addr_r   <= bus.dcache_wr_addr;
                        mem_wdata_r  <= bus.dcache_wr_data;
                        wr_ack_r     <= 1'b1;
                        busy_r       <= 1'b1;
                    end else if (bus.dcache_miss || bus.icache_miss) begin
                        state_r      <= FILL_ISSUE;
                        owner_d_r    <= bus.dcache_miss;
                        base_r       <= grant_base_s;
                        issue_cnt_r  <= {CW{1'b0}};
                        recv_cnt_r   <= {CW{1'b0}};
                        mem_enable_r <= 1'b1;
                        mem_wr_r     <= 1'b0;
                        mem_addr_r   <= grant_base_s;
                        busy_r       <= 1'b1;
                    end
                end
                WRITE: begin
                    state_r      <= IDLE;
                    mem_enable_r <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    mem_addr_r   <= 16'h0000;
                    mem_wdata_r  <= 16'h0000;
                    wr_ack_r     <= 1'b0;
                    busy_r       <= 1'b0;
                end
                FILL_ISSUE: begin
                    issue_cnt_r <= issue_next_s;
                    if (issue_cnt_r == LAST_IDX) begin
                        state_r      <= FILL_DRAIN;
                        mem_enable_r <= 1'b0;
                        mem_addr_r   <= 16'h0000;
                    end else begin
                        mem_addr_r <= word_addr(base_r, issue_next_s);
                    end
                end
                FILL_DRAIN: begin
                    state_r <= FILL_DRAIN;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            // The last returned word ends the fill regardless of issue progress.
            if (last_word_s) begin
                state_r      <= IDLE;
                mem_enable_r <= 1'b0;
                mem_addr_r   <= 16'h0000;
                busy_r       <= 1'b0;
            end
        end
    end

    assign bus.mem_enable       = mem_enable_r;
    assign bus.mem_wr           = mem_wr_r;
    assign bus.mem_addr         = mem_addr_r;
    assign bus.mem_wdata        = mem_wdata_r;
    assign bus.wr_ack           = wr_ack_r;
    assign bus.busy             = busy_r;
    assign bus.fill_addr        = fill_active_s ? word_addr(base_r, recv_cnt_r) : 16'h0000;
    assign bus.fill_data        = fill_active_s ? bus.mem_rdata : 16'h0000;
    assign bus.icache_fill_we   = fill_active_s && !owner_d_r;
    assign bus.dcache_fill_we   = fill_active_s && owner_d_r;
    assign bus.icache_fill_done = last_word_s && !owner_d_r;
    assign bus.dcache_fill_done = last_word_s && owner_d_r;
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: stimulus pushes expected memory accesses and
// fill writes; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_fill_arbiter;
    localparam int BW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    mem_fill_arbiter_if bus();

    mem_fill_arbiter #(.BLOCK_WORDS(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] gap;
    } acc_t;

    typedef struct packed {
        logic        own_d;
        logic [15:0] addr;
        logic [15:0] data;
        logic        done;
    } fill_t;

    acc_t  exp_acc[$];
    fill_t exp_fill[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_acc = 0;
    logic [15:0] seed = 16'h0000;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ seed;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory: fixed-latency pipelined reads returning a pseudo-random word per address.
    logic [LAT-1:0] vpipe;
    logic [15:0]    dpipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe    <= {vpipe[LAT-2:0], bus.mem_enable && !bus.mem_wr};
            dpipe[0] <= init_word(bus.mem_addr);
            for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
        end
    end
    assign bus.mem_data_valid = vpipe[LAT-1] && !rst;
    assign bus.mem_rdata      = bus.mem_data_valid ? dpipe[LAT-1] : 16'h0000;

    // Monitor: every memory access and every fill write must match the head of its queue.
    always @(negedge clk) begin
        acc_t  ea;
        fill_t ef;
        if (!rst) begin
            if (bus.mem_enable) begin
                if (exp_acc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL acc_unexpected actual=%h expected=none", bus.mem_addr);
                end else begin
                    ea = exp_acc.pop_front();
                    check("mem_access",
                          {bus.mem_wr, bus.wr_ack, bus.busy, bus.mem_addr,
                           (bus.mem_wr ? bus.mem_wdata : 16'h0000), 16'(cyc - last_acc)},
                          {ea.wr, ea.wr, 1'b1, ea.addr, ea.wdata, ea.gap});
                end
                last_acc = cyc;
            end
            if (bus.icache_fill_we || bus.dcache_fill_we) begin
                if (exp_fill.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fill_unexpected actual=%h expected=none", bus.fill_addr);
                end else begin
                    ef = exp_fill.pop_front();
                    check("fill_write",
                          {bus.icache_fill_we, bus.dcache_fill_we, bus.icache_fill_done,
                           bus.dcache_fill_done, bus.fill_addr, bus.fill_data},
                          {!ef.own_d, ef.own_d, ef.done && !ef.own_d, ef.done && ef.own_d,
                           ef.addr, ef.data});
                end
            end
            if ((bus.wr_ack && !bus.mem_enable) ||
                ((bus.icache_fill_done || bus.dcache_fill_done) &&
                 !(bus.icache_fill_we || bus.dcache_fill_we))) begin
                checks++; errors++;
                $display("FAIL stray_pulse actual=%b%b%b expected=000",
                         bus.wr_ack, bus.icache_fill_done, bus.dcache_fill_done);
            end
        end
    end

    task automatic push_fill(input logic own_d, input logic [15:0] addr, input logic [15:0] first_gap);
        logic [15:0] base;
        logic [15:0] a;
        base = addr & ~16'(2 * BW - 1);
        for (int k = 0; k < BW; k++) begin
            a = base + 16'(2 * k);
            exp_acc.push_back('{wr: 1'b0, addr: a, wdata: 16'h0000,
                                gap: (k == 0) ? first_gap : 16'd1});
            exp_fill.push_back('{own_d: own_d, addr: a, data: init_word(a), done: (k == BW - 1)});
        end
    endtask

    // Reference order: fixed priority at each idle point; a store raised during the
    // first fill is served right after it.
    task automatic plan(input logic w, input logic d, input logic i, input logic mid,
                        input logic [15:0] wa, input logic [15:0] wd,
                        input logic [15:0] da, input logic [15:0] ia);
        int fills[$];
        int kinds[$];
        logic [15:0] g;
        if (d) fills.push_back(1);
        if (i) fills.push_back(2);
        if (w) kinds.push_back(0);
        foreach (fills[n]) begin
            kinds.push_back(fills[n]);
            if (mid && n == 0) kinds.push_back(0);
        end
        g = 16'd1;
        foreach (kinds[n]) begin
            if (kinds[n] == 0) begin
                exp_acc.push_back('{wr: 1'b1, addr: wa, wdata: wd, gap: g});
                g = 16'd2;
            end else begin
                push_fill(kinds[n] == 1, (kinds[n] == 1) ? da : ia, g);
                g = 16'(LAT + 2);
            end
        end
    endtask

    task automatic run(input logic w, input logic d, input logic i, input logic mid, input int mid_off,
                       input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] da, input logic [15:0] ia);
        int  n;
        logic pend_mid;
        plan(w, d, i, mid, wa, wd, da, ia);
        @(posedge clk); #1;
        bus.dcache_wr_addr   = wa;
        bus.dcache_wr_data   = wd;
        bus.dcache_miss_addr = da;
        bus.icache_miss_addr = ia;
        bus.dcache_wr_req    = w;
        bus.dcache_miss      = d;
        bus.icache_miss      = i;
        last_acc = cyc;
        pend_mid = mid;
        n = 0;
        while ((bus.dcache_wr_req || bus.dcache_miss || bus.icache_miss || pend_mid) && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.wr_ack) bus.dcache_wr_req = 1'b0;
            if (bus.dcache_fill_done) bus.dcache_miss = 1'b0;
            if (bus.icache_fill_done) bus.icache_miss = 1'b0;
            if (pend_mid && n == mid_off) begin
                bus.dcache_wr_req = 1'b1;
                pend_mid = 1'b0;
            end
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout actual=%0d expected=<200", n);
            bus.dcache_wr_req = 1'b0; bus.dcache_miss = 1'b0; bus.icache_miss = 1'b0;
        end
        @(negedge clk);
        check("idle_after", {bus.busy, exp_acc.size() == 0, exp_fill.size() == 0}, {1'b0, 1'b1, 1'b1});
        exp_acc.delete();
        exp_fill.delete();
    endtask

    task automatic check_quiet(input string name);
        check(name, {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_addr,
                     bus.fill_data, bus.icache_fill_we, bus.dcache_fill_we,
                     bus.icache_fill_done, bus.dcache_fill_done, bus.wr_ack, bus.busy}, 80'h0);
    endtask

    initial begin
        logic w, d, i, mid;
        int   n;
        seed = 16'($urandom);
        rst = 1'b1;
        bus.icache_miss = 1'b0; bus.icache_miss_addr = 16'h0000;
        bus.dcache_miss = 1'b0; bus.dcache_miss_addr = 16'h0000;
        bus.dcache_wr_req = 1'b0; bus.dcache_wr_addr = 16'h0000; bus.dcache_wr_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("reset_state");

        run(1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0046);
        run(1'b0, 1'b1, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 16'h1238, 16'h0010);
        run(1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h2002, 16'hBEEF, 16'h0510, 16'h0000);
        run(1'b0, 1'b0, 1'b1, 1'b1, 4, 16'h0A0C, 16'h1234, 16'h0000, 16'h0080);

        // Reset after three returned words abandons the fill.
        plan(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0300);
        @(posedge clk); #1;
        bus.icache_miss_addr = 16'h0300;
        bus.icache_miss = 1'b1;
        last_acc = cyc;
        n = 0;
        while (exp_fill.size() > BW - 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_wait", {exp_fill.size() == BW - 3}, {1'b1});
        rst = 1'b1;
        bus.icache_miss = 1'b0;
        exp_acc.delete();
        exp_fill.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_mid_reset");
        run(1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0300);

        run(1'b0, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 16'hFFFA, 16'h0000);

        for (int t = 0; t < 16; t++) begin
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            i = 1'($urandom_range(0, 1));
            if (!w && !d && !i) i = 1'b1;
            mid = !w && (d || i) && (1'($urandom_range(0, 1)));
            run(w, d, i, mid, int'($urandom_range(2, 6)),
                16'($urandom) & 16'hFFFE, 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Controller that shares the single main-memory port between three requesters: I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences 8-word block fills as one read issued per cycle, then steers the returning words into the owning cache.
- Sits between the fetch/memory-stage caches and main memory. While it is busy, the hazard unit stalls fetch (the PC enable is deasserted).

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; power of 2, 2..16.
- BLOCK_BYTES, 2*BLOCK_WORDS, derived, not overridable; block alignment in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- icache_miss  in  1  I-cache miss, level; held until icache_fill_done
- icache_miss_addr  in  16  byte address of missing instruction
- dcache_miss  in  1  D-cache miss, level; held until dcache_fill_done
- dcache_miss_addr  in  16  byte address of missing data
- dcache_wr_req  in  1  write-through store request, level; held until wr_ack
- dcache_wr_addr  in  16  store byte address
- dcache_wr_data  in  16  store data
- mem_enable  out  1  main-memory access strobe
- mem_wr  out  1  1 = write, 0 = read (valid with mem_enable)
- mem_addr  out  16  main-memory byte address
- mem_wdata  out  16  main-memory write data
- mem_data_valid  in  1  read data returning this cycle (fixed pipelined latency, in issue order)
- mem_rdata  in  16  returned read data
- fill_addr  out  16  byte address of word being written into a cache
- fill_data  out  16  word being written into a cache (= mem_rdata)
- icache_fill_we  out  1  write fill_data into I-cache data array
- dcache_fill_we  out  1  write fill_data into D-cache data array
- icache_fill_done  out  1  1-cycle pulse: last I-cache word written, tag may be validated
- dcache_fill_done  out  1  1-cycle pulse: last D-cache word written
- wr_ack  out  1  1-cycle pulse: store accepted by memory
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, WRITE, FILL_ISSUE, FILL_DRAIN.
- Reset: state IDLE; all counters 0; owner cleared. Every output 0 (the address and data outputs read 0 while idle).
- IDLE arbitration (fixed priority):
  - dcache_wr_req first, then dcache_miss, then icache_miss.
  - The grant is registered: a request seen in cycle t gets its first memory access in cycle t+1.
  - If nothing is pending, stay in IDLE.
- WRITE (exactly 1 cycle):
  - Drive mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, wr_ack=1.
  - Next state is IDLE.
- Fill grant:
  - Latch owner (I or D).
  - Latch base = miss_addr with its low log2(BLOCK_BYTES) bits cleared.
  - Clear issue_cnt and recv_cnt.
- FILL_ISSUE:
  - mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments each cycle.
  - After BLOCK_WORDS cycles go to FILL_DRAIN.
  - Exactly BLOCK_WORDS reads are issued, back-to-back, in ascending address order.
- Data return (any fill state):
  - On mem_data_valid, fill_data=mem_rdata and fill_addr=base+2*recv_cnt.
  - The owner's fill_we is asserted combinationally in the same cycle; recv_cnt increments.
  - Returns can overlap FILL_ISSUE, so both counters may move in the same cycle.
- Completion:
  - In the cycle the BLOCK_WORDS-th valid arrives (recv_cnt == BLOCK_WORDS-1), the owner's fill_done pulses together with the last fill_we.
  - Next state is IDLE.
  - mem_data_valid outside a fill is ignored; no fill_we is asserted.
- Requester contract: a requester drops its request in the cycle after its done/ack pulse. The FSM therefore never regrants a just-serviced request.
- Pending requests during WRITE or a fill are not acknowledged. They are serviced in IDLE, in priority order.
- The non-owner's fill_we and fill_done stay 0 throughout.
- Counter widths: log2(BLOCK_WORDS)+1 bits, with no wrap within a fill. Address arithmetic is 16-bit modulo: a block at 0xFFF0 issues addresses up to 0xFFFE, with no carry out.
- Reset mid-operation: return to IDLE on the next edge; no done pulse; the fill is abandoned. Main memory shares rst, so no stale valids are expected.

Test Plan:
- I-miss only: icache_miss_addr=0x0046 at cycle 0 -> mem reads 0x0040..0x004E on cycles 1..8; 8 icache_fill_we with fill_addr 0x0040..0x004E; icache_fill_done coincident with the 0x004E write; busy low the next cycle.
- Simultaneous dcache_miss (0x1238) and icache_miss (0x0010) -> D fill of 0x1230..0x123E completes first; I fill 0x0010..0x001E starts the cycle after dcache_fill_done+IDLE; no dcache_fill_we during the I fill.
- Store 0xBEEF at 0x2002 raised together with dcache_miss in IDLE -> WRITE first (mem_wr=1, wr_ack=1 for one cycle), then the D fill.
- Store raised mid-I-fill -> no mem_wr and no wr_ack until after icache_fill_done; then a single-cycle write.
- rst asserted after 3 returned words -> busy=0, all outputs 0, no fill_done; a fresh miss then restarts at word 0.
- Wrap: dcache_miss_addr=0xFFFA -> reads 0xFFF0..0xFFFE; fill_addr never exceeds 0xFFFE.
